// File: rtl/com_loader.sv
// Byte-stream program loader: receives a 16-bit word count and 2N data bytes,
// writes words to data memory, then runs until end_process. COM_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module com_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        end_process,
    output logic [15:0] com_data_in,
    output logic [15:0] com_addr,
    output logic        com_wr_en,
    output logic [1:0]  status,
    output logic        err
);

    // state  | meaning
    // IDLE   | no program; next byte is count high
    // CNT_HI | awaiting count high byte
    // CNT_LO | count high held, awaiting count low byte
    // DAT_HI | awaiting data high byte of word idx
    // DAT_LO | data high held, awaiting data low byte
    // CHK    | all words written, awaiting checksum byte (macro only)
    // RUN    | processor executing, byte stream blocked
    // DONE   | processor finished; next byte starts a new load
`ifdef COM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, RUN, DONE, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, RUN, DONE} state_t;
`endif

    state_t      state, state_d;
    logic [7:0]  cnt_hi, cnt_hi_d;
    logic [7:0]  dat_hi, dat_hi_d;
    logic [15:0] n_words, n_words_d;
    logic [15:0] idx, idx_d;
    logic [15:0] data_q, data_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        accept;
    logic [15:0] count_w;
    logic [15:0] idx_inc;
`ifdef COM_LOADER_CHECKSUM_EN
    logic [7:0]  csum, csum_d;
`endif

    assign rx_ready    = (state != RUN);
    assign accept      = rx_valid && rx_ready;
    assign count_w     = {cnt_hi, rx_data};
    assign idx_inc     = idx + 16'd1;
    assign com_data_in = data_q;
    assign com_addr    = addr_q;
    assign com_wr_en   = wr_q;
    assign err         = err_q;

    always_comb begin
        case (state)
            IDLE:    status = 2'b00;
            RUN:     status = 2'b10;
            DONE:    status = 2'b11;
            default: status = 2'b01;
        endcase
    end

    always_comb begin
        state_d   = state;
        cnt_hi_d  = cnt_hi;
        dat_hi_d  = dat_hi;
        n_words_d = n_words;
        idx_d     = idx;
        data_d    = data_q;
        addr_d    = addr_q;
        wr_d      = 1'b0;
        err_d     = err_q;
`ifdef COM_LOADER_CHECKSUM_EN
        csum_d    = csum;
`endif
        case (state)
            IDLE, CNT_HI, DONE: begin
                if (accept) begin
                    cnt_hi_d = rx_data;
                    err_d    = 1'b0;
                    state_d  = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    n_words_d = count_w;
                    idx_d     = 16'd0;
`ifdef COM_LOADER_CHECKSUM_EN
                    csum_d    = 8'h00;
`endif
                    if (count_w == 16'd0) begin
`ifdef COM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = RUN;
`endif
                    end else if (count_w > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (accept) begin
                    dat_hi_d = rx_data;
`ifdef COM_LOADER_CHECKSUM_EN
                    csum_d   = csum ^ rx_data;
`endif
                    state_d  = DAT_LO;
                end
            end
            DAT_LO: begin
                if (accept) begin
                    data_d = {dat_hi, rx_data};
                    addr_d = BASE_ADDR + idx;
                    wr_d   = 1'b1;
                    idx_d  = idx_inc;
`ifdef COM_LOADER_CHECKSUM_EN
                    csum_d = csum ^ rx_data;
`endif
                    // the final word's strobe and the RUN/CHK entry share one edge
                    if (idx_inc == n_words) begin
`ifdef COM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = RUN;
`endif
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            RUN: begin
                if (end_process)
                    state_d = DONE;
            end
`ifdef COM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (rx_data == csum) begin
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt_hi  <= 8'h00;
            dat_hi  <= 8'h00;
            n_words <= 16'h0000;
            idx     <= 16'h0000;
            data_q  <= 16'h0000;
            addr_q  <= 16'h0000;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
            csum    <= 8'h00;
`endif
        end else begin
            state   <= state_d;
            cnt_hi  <= cnt_hi_d;
            dat_hi  <= dat_hi_d;
            n_words <= n_words_d;
            idx     <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
`ifdef COM_LOADER_CHECKSUM_EN
            csum    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_com_loader.sv
// Directed bench for com_loader: two instances (BASE_ADDR 0 and FFFF) share one byte stream.
module tb_com_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        end_process;

    logic        a_ready, a_wr, a_err;
    logic [15:0] a_data, a_addr;
    logic [1:0]  a_status;
    logic        b_ready, b_wr, b_err;
    logic [15:0] b_data, b_addr;
    logic [1:0]  b_status;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] wa_addr[$];
    logic [15:0] wa_data[$];
    logic [15:0] wb_addr[$];
    int          nw0;

    always #5 clk = ~clk;

    com_loader u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(a_ready),
        .end_process(end_process), .com_data_in(a_data), .com_addr(a_addr),
        .com_wr_en(a_wr), .status(a_status), .err(a_err)
    );

    com_loader #(.BASE_ADDR(16'hFFFF)) u_dut_wrap (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(b_ready),
        .end_process(end_process), .com_data_in(b_data), .com_addr(b_addr),
        .com_wr_en(b_wr), .status(b_status), .err(b_err)
    );

    always @(negedge clk) begin
        if (a_wr) begin
            wa_addr.push_back(a_addr);
            wa_data.push_back(a_data);
        end
        if (b_wr)
            wb_addr.push_back(b_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the following negedge
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_end();
        end_process = 1'b1;
        @(negedge clk);
        end_process = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; end_process = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_status", {30'd0, a_status}, 32'd0);
        chk("rst_ready",  {31'd0, a_ready},  32'd1);
        chk("rst_wr",     {31'd0, a_wr},     32'd0);
        chk("rst_data",   {16'd0, a_data},   32'd0);
        chk("rst_addr",   {16'd0, a_addr},   32'd0);
        chk("rst_err",    {31'd0, a_err},    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic two-word load with a stall in the middle
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        chk("load_status", {30'd0, a_status}, 32'd1);
        repeat (3) @(negedge clk);
        chk("stall_status", {30'd0, a_status}, 32'd1);
        chk("stall_nowr", wa_addr.size(), 32'd0);
        send_byte(8'h34);
        chk("w0_pulse", {31'd0, a_wr}, 32'd1);
        send_byte(8'hAB); send_byte(8'hCD);
        chk("w1_pulse", {31'd0, a_wr}, 32'd1);
`ifdef COM_LOADER_CHECKSUM_EN
        chk("chk_status", {30'd0, a_status}, 32'd1);
        send_byte(8'h40);
`else
        chk("run_with_wr", {30'd0, a_status}, 32'd2);
`endif
        @(negedge clk);
        chk("n_writes", wa_addr.size(), 32'd2);
        if (wa_addr.size() == 2) begin
            chk("w0_addr", {16'd0, wa_addr[0]}, 32'h0000);
            chk("w0_data", {16'd0, wa_data[0]}, 32'h1234);
            chk("w1_addr", {16'd0, wa_addr[1]}, 32'h0001);
            chk("w1_data", {16'd0, wa_data[1]}, 32'hABCD);
        end
        chk("wrap_n", wb_addr.size(), 32'd2);
        if (wb_addr.size() == 2) begin
            chk("wrap_a0", {16'd0, wb_addr[0]}, 32'hFFFF);
            chk("wrap_a1", {16'd0, wb_addr[1]}, 32'h0000);
        end
        chk("run_status", {30'd0, a_status}, 32'd2);
        chk("run_ready",  {31'd0, a_ready},  32'd0);
        chk("hold_data",  {16'd0, a_data},   32'hABCD);
        chk("hold_addr",  {16'd0, a_addr},   32'h0001);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        chk("run_hold", {30'd0, a_status}, 32'd2);
        pulse_end();
        chk("done_status", {30'd0, a_status}, 32'd3);
        chk("done_ready",  {31'd0, a_ready},  32'd1);
        end_process = 1'b1;
        @(negedge clk);
        end_process = 1'b0;
        chk("done_ignore_end", {30'd0, a_status}, 32'd3);

        // zero-length program from DONE
        send_byte(8'h00); send_byte(8'h00);
`ifdef COM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        @(negedge clk);
        chk("n0_status", {30'd0, a_status}, 32'd2);
        chk("n0_nowr", wa_addr.size(), 32'd2);
        pulse_end();
        chk("n0_done", {30'd0, a_status}, 32'd3);

        // oversize count rejected, next byte clears err
        send_byte(8'h10); send_byte(8'h01);
        @(negedge clk);
        chk("big_err",    {31'd0, a_err},    32'd1);
        chk("big_status", {30'd0, a_status}, 32'd0);
        chk("big_nowr", wa_addr.size(), 32'd2);
        send_byte(8'h10);
        chk("err_clear",  {31'd0, a_err},    32'd0);
        chk("clr_status", {30'd0, a_status}, 32'd1);
        send_byte(8'h00);
        chk("max_ok_err",    {31'd0, a_err},    32'd0);
        chk("max_ok_status", {30'd0, a_status}, 32'd1);

        // reset between high and low byte of word 3
        do_reset();
        nw0 = wa_addr.size();
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h33);
        send_byte(8'h44);
        chk("pre_rst_addr", {16'd0, a_addr}, 32'h0002);
        chk("pre_rst_data", {16'd0, a_data}, 32'h3333);
        #2 rst = 1'b1;
        #1;
        chk("arst_status", {30'd0, a_status}, 32'd0);
        chk("arst_data",   {16'd0, a_data},   32'd0);
        chk("arst_addr",   {16'd0, a_addr},   32'd0);
        chk("arst_wr",     {31'd0, a_wr},     32'd0);
        chk("arst_ready",  {31'd0, a_ready},  32'd1);
        @(negedge clk);
        rx_data = 8'h44; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_nwr", wa_addr.size() - nw0, 32'd3);
        if (wa_addr.size() - nw0 == 3)
            chk("w2_data", {16'd0, wa_data[nw0 + 2]}, 32'h3333);
        chk("arst_idle", {30'd0, a_status}, 32'd0);

`ifdef COM_LOADER_CHECKSUM_EN
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h26);
        chk("csum_ok", {30'd0, a_status}, 32'd2);
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h27);
        chk("csum_bad_err",    {31'd0, a_err},    32'd1);
        chk("csum_bad_status", {30'd0, a_status}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
